instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Initiator side of the single-cycle instruction memory port. After reset it makes the memory load its image, then fetches one 32-bit word per cycle from a program counter. Fetched words are buffered in a small FIFO with valid/ready toward decode, and the unit handles branch redirects. On halt it requests a memory dump and stops.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC after reset; bits [1:0] must be 0.
- `FIFO_DEPTH`, default 2: instruction queue entries; power of 2, ≥ 2.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `mem_addr`  out  32  byte address to instruction memory; equals PC.
- `mem_enable`  out  1  memory read strobe.
- `mem_wr`  out  1  tied 0.
- `mem_data_in`  out  32  tied 0.
- `mem_rst`  out  1  memory load request (memory's active-high synchronous reset).
- `mem_createdump`  out  1  one-cycle dump request.
- `mem_data`  in  32  combinational read data, valid in the same cycle as `mem_addr`/`mem_enable`.
- `redirect_valid`  in  1  branch/jump redirect strobe.
- `redirect_pc`  in  32  redirect target; bits [1:0] are ignored and forced to 0.
- `halt_req`  in  1  halt strobe.
- `inst_valid`  out  1  queue head is valid.
- `inst`  out  32  head instruction word.
- `inst_pc`  out  32  head instruction address.
- `inst_ready`  in  1  decode accepts the head.
- `halted`  out  1  fetch stopped; sticky until reset.

## Operation
- **States:** LOAD, FETCH, DUMP, HALTED.
- **Reset (`rst_n`=0):**
  - state=LOAD; PC=RESET_PC; queue empty.
  - Output values: `inst_valid`=0, `inst`=0, `inst_pc`=0, `halted`=0, `mem_enable`=0, `mem_createdump`=0.
  - `mem_rst`=1, because it decodes from LOAD.
- **LOAD:**
  - Lasts exactly one cycle after reset release.
  - `mem_rst`=1, `mem_enable`=0.
  - Next state is FETCH unconditionally; `redirect_valid` and `halt_req` are ignored.
- **FETCH:**
  - `mem_rst`=0.
  - Fetch condition: `mem_enable` = !redirect_valid & !halt_req & (count<FIFO_DEPTH | pop).
  - When fetching, at the clock edge push {PC, `mem_data`} and set PC=PC+4, wrapping modulo 2^32.
- **Redirect in FETCH:**
  - Flush the queue, including any same-cycle pop; `inst_valid` is 0 next cycle.
  - PC={redirect_pc[31:2],2'b00}; no push that cycle.
- **Halt in FETCH:**
  - Flush the queue; go to DUMP.
  - Halt takes precedence over a simultaneous redirect.
- **DUMP:**
  - `mem_createdump`=1 and `mem_enable`=0 for one cycle.
  - Next state is HALTED.
- **HALTED:**
  - `halted`=1; all memory strobes 0; queue empty.
  - Inputs are ignored until `rst_n` is asserted.
- **Queue:**
  - pop = `inst_valid` & `inst_ready`.
  - `inst`/`inst_pc` are read combinationally from the head entry.
  - Simultaneous push and pop is legal when full, and legal when empty only if `inst_valid` is already 1 (otherwise no pop occurs).
  - Count never exceeds FIFO_DEPTH.
- **Address range:** the memory is 64 KB. The PC is not truncated; software keeps it below 16'hFFFC.

## Timing
- Reset release edge → LOAD for 1 cycle → first `mem_enable` in the following cycle.
- `inst_valid` rises one cycle after the first fetch.
- Fetch-to-`inst_valid` latency: 1 cycle. Sustained throughput: 1 instruction/cycle with `inst_ready` held at 1.
- Redirect:
  - Accepted at edge N.
  - Target fetched in cycle N+1.
  - Target appears on `inst` in cycle N+2.
- Halt:
  - Accepted at edge N.
  - `mem_createdump` high in cycle N+1.
  - `halted` high from cycle N+2 onward.
- Asynchronous reset mid-operation returns all state to reset values immediately; the next LOAD re-issues `mem_rst`.

## Structure
- Shared package `fetch_pkg`:
  - State enum: LOAD, FETCH, DUMP, HALTED.
  - INSTR_W=32, ADDR_W=32, PC_STEP=4.
- Sub-module `fetch_fifo`:
  - Synchronous FIFO, depth FIFO_DEPTH, 64-bit entries {pc, inst}.
  - Ports: push, pop, flush, count, head.
- The top level holds the PC register, state machine and memory-port decode.

## Test plan
- **Reset/load:** deassert `rst_n` → `mem_rst`=1 for exactly 1 cycle, then `mem_addr`=0x0 with `mem_enable`=1; the words at 0x0 and 0x4 appear on `inst` with `inst_pc` 0x0 then 0x4.
- **Streaming:** `inst_ready`=1 for 10 cycles → `inst_pc` sequence 0x0, 0x4, …, 0x24; one instruction per cycle, no gaps.
- **Backpressure:** `inst_ready`=0 → the queue fills to 2 and `mem_enable` drops. Raise `inst_ready` → the head is inst_pc 0x0 and no words are lost or duplicated.
- **Redirect:** `redirect_pc`=0x103 while the queue is full → flush. `inst_pc`=0x100 two cycles later; the old entries never appear.
- **Halt + redirect together:** assert both `halt_req` and `redirect_valid` → halt wins. `mem_createdump` is high for exactly 1 cycle, `halted`=1 is sticky, and `mem_enable` stays 0 afterwards.
- **Async reset mid-stream:** pulse `rst_n` low between edges → outputs clear immediately; LOAD repeats and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and widths for the instruction fetch unit.
package fetch_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned PC_STEP = 4;

  typedef enum logic [1:0] {
    LOAD,
    FETCH,
    DUMP,
    HALTED
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction queue: synchronous FIFO of {pc, inst} with flush taking priority over push/pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  fetch_entry_t       din,
  output logic [CNT_W-1:0]   count,
  output fetch_entry_t       head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  fetch_entry_t     mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  // A pop frees a slot in the same cycle, so a full queue can still accept a push.
  assign do_pop  = pop & (count != '0);
  assign do_push = push & ((count < CNT_W'(DEPTH)) | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch initiator: memory load, sequential fetch into a queue, redirect and halt/dump.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned       FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_enable,
  output logic               mem_wr,
  output logic [INSTR_W-1:0] mem_data_in,
  output logic               mem_rst,
  output logic               mem_createdump,
  input  logic [INSTR_W-1:0] mem_data,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               halt_req,
  output logic               inst_valid,
  output logic [INSTR_W-1:0] inst,
  output logic [ADDR_W-1:0]  inst_pc,
  input  logic               inst_ready,
  output logic               halted
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  fetch_state_t      state;
  fetch_state_t      state_nxt;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_nxt;
  logic              fetch;
  logic              flush;
  logic              load;
  logic              dump;
  logic              pop;
  logic [CNT_W-1:0]  count;
  fetch_entry_t      head;
  fetch_entry_t      push_entry;

  assign inst_valid = (count != '0);
  assign pop        = inst_valid & inst_ready;
  assign push_entry = '{pc: pc, inst: mem_data};

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fetch),
    .pop   (pop),
    .flush (flush),
    .din   (push_entry),
    .count (count),
    .head  (head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD;
      pc    <= RESET_PC;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  // Halt beats redirect; both suppress the fetch and flush the queue.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    fetch     = 1'b0;
    flush     = 1'b0;
    load      = 1'b0;
    dump      = 1'b0;
    case (state)
      LOAD: begin
        load      = 1'b1;
        state_nxt = FETCH;
      end
      FETCH: begin
        if (halt_req) begin
          flush     = 1'b1;
          state_nxt = DUMP;
        end else if (redirect_valid) begin
          flush  = 1'b1;
          pc_nxt = redirect_pc & ~ADDR_W'(PC_STEP - 1);
        end else if ((count < CNT_W'(FIFO_DEPTH)) || pop) begin
          fetch  = 1'b1;
          pc_nxt = pc + ADDR_W'(PC_STEP);
        end
      end
      DUMP: begin
        dump      = 1'b1;
        state_nxt = HALTED;
      end
      HALTED:  state_nxt = HALTED;
      default: state_nxt = LOAD;
    endcase
  end

  assign mem_addr       = pc;
  assign mem_enable     = fetch;
  assign mem_wr         = 1'b0;
  assign mem_data_in    = '0;
  assign mem_rst        = load;
  assign mem_createdump = dump;
  assign halted         = (state == HALTED);
  assign inst           = inst_valid ? head.inst : '0;
  assign inst_pc        = inst_valid ? head.pc : '0;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with an expected-PC scoreboard drained on each accepted instruction.
module tb_instruction_fetch;

  logic        clk;
  logic        rst_n;
  logic [31:0] mem_addr;
  logic        mem_enable;
  logic        mem_wr;
  logic [31:0] mem_data_in;
  logic        mem_rst;
  logic        mem_createdump;
  logic [31:0] mem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        halted;

  int          n_cmp;
  int          n_err;
  logic [31:0] sb [$];
  logic [31:0] exp_pc;

  instruction_fetch #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_addr       (mem_addr),
    .mem_enable     (mem_enable),
    .mem_wr         (mem_wr),
    .mem_data_in    (mem_data_in),
    .mem_rst        (mem_rst),
    .mem_createdump (mem_createdump),
    .mem_data       (mem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready),
    .halted         (halted)
  );

  // Instruction memory image: each word is a fixed scramble of its own address.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  assign mem_data = memf(mem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Check the head against the next expected PC whenever decode accepts it this cycle.
  task automatic consume();
    if (inst_valid === 1'b1 && inst_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_pop", inst_pc, 32'hFFFF_FFFF);
      end else begin
        exp_pc = sb.pop_front();
        chk("sb_inst_pc", inst_pc, exp_pc);
        chk("sb_inst", inst, memf(exp_pc));
      end
    end
  endtask

  // Enter the next cycle: drive inputs at the falling edge, settle, then score the accept.
  task automatic cyc(input logic rdy, input logic rv, input logic [31:0] rpc, input logic hlt);
    @(negedge clk);
    inst_ready     = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    halt_req       = hlt;
    #1;
    consume();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    n_cmp          = 0;
    n_err          = 0;
    rst_n          = 1'b1;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    halt_req       = 1'b0;
    #1 rst_n = 1'b0;
    #2;

    // Reset values
    chk("rst_mem_rst", 32'(mem_rst), 32'd1);
    chk("rst_mem_enable", 32'(mem_enable), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_dump", 32'(mem_createdump), 32'd0);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_mem_data_in", mem_data_in, 32'h0);

    // LOAD cycle after release, then first fetch at RESET_PC
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("load_mem_rst", 32'(mem_rst), 32'd1);
    chk("load_mem_enable", 32'(mem_enable), 32'd0);
    for (int i = 0; i < 10; i++) sb.push_back(32'(i * 4));
    cyc(1'b0, 1'b0, 32'h0, 1'b0);
    chk("f0_mem_rst", 32'(mem_rst), 32'd0);
    chk("f0_mem_enable", 32'(mem_enable), 32'd1);
    chk("f0_mem_addr", mem_addr, 32'h0);
    chk("f0_inst_valid", 32'(inst_valid), 32'd0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0);
    chk("f1_inst_valid", 32'(inst_valid), 32'd1);
    chk("f1_inst_pc", inst_pc, 32'h0);
    chk("f1_inst", inst, memf(32'h0));
    chk("f1_mem_addr", mem_addr, 32'h4);

    // Backpressure: queue fills to two and fetch stalls
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 1'b0, 32'h0, 1'b0);
      chk("bp_mem_enable", 32'(mem_enable), 32'd0);
      chk("bp_head_pc", inst_pc, 32'h0);
    end

    // Streaming: one instruction per cycle, no gaps
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b0, 32'h0, 1'b0);
      chk("stream_valid", 32'(inst_valid), 32'd1);
    end
    cyc(1'b0, 1'b0, 32'h0, 1'b0);
    chk("stream_drained", 32'(sb.size()), 32'd0);
    chk("stream_next_head", inst_pc, 32'h28);

    // Redirect while full: flush, target fetched next cycle, shown the cycle after
    cyc(1'b0, 1'b1, 32'h103, 1'b0);
    chk("rd_mem_enable", 32'(mem_enable), 32'd0);
    chk("rd_full_valid", 32'(inst_valid), 32'd1);
    sb.push_back(32'h100);
    sb.push_back(32'h104);
    sb.push_back(32'h108);
    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    chk("rd_flushed", 32'(inst_valid), 32'd0);
    chk("rd_mem_addr", mem_addr, 32'h100);
    chk("rd_mem_enable2", 32'(mem_enable), 32'd1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0);
    chk("rd_drained", 32'(sb.size()), 32'd0);

    // Halt with simultaneous redirect: halt wins
    cyc(1'b0, 1'b1, 32'h200, 1'b1);
    chk("h_mem_enable", 32'(mem_enable), 32'd0);
    chk("h_dump_early", 32'(mem_createdump), 32'd0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    chk("h_dump", 32'(mem_createdump), 32'd1);
    chk("h_dump_enable", 32'(mem_enable), 32'd0);
    chk("h_dump_valid", 32'(inst_valid), 32'd0);
    chk("h_dump_halted", 32'(halted), 32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b1, 32'h300, i[0]);
      chk("h_halted", 32'(halted), 32'd1);
      chk("h_dump_once", 32'(mem_createdump), 32'd0);
      chk("h_enable_off", 32'(mem_enable), 32'd0);
      chk("h_valid_off", 32'(inst_valid), 32'd0);
      chk("h_mem_rst_off", 32'(mem_rst), 32'd0);
    end

    // Reset out of HALTED, stream a few words
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("hr_halted", 32'(halted), 32'd0);
    @(negedge clk);
    rst_n          = 1'b1;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    halt_req       = 1'b0;
    #1;
    chk("hr_load", 32'(mem_rst), 32'd1);
    sb.push_back(32'h0);
    sb.push_back(32'h4);
    sb.push_back(32'h8);
    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    chk("hr_mem_addr", mem_addr, 32'h0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0);
    chk("hr_drained", 32'(sb.size()), 32'd0);
    chk("hr_busy_valid", 32'(inst_valid), 32'd1);

    // Asynchronous reset pulse between edges clears outputs immediately
    #1 rst_n = 1'b0;
    #1;
    chk("ar_inst_valid", 32'(inst_valid), 32'd0);
    chk("ar_inst_pc", inst_pc, 32'h0);
    chk("ar_mem_rst", 32'(mem_rst), 32'd1);
    chk("ar_mem_enable", 32'(mem_enable), 32'd0);
    chk("ar_mem_addr", mem_addr, 32'h0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ar_load", 32'(mem_rst), 32'd1);
    chk("ar_load_enable", 32'(mem_enable), 32'd0);
    sb.push_back(32'h0);
    sb.push_back(32'h4);
    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    chk("ar_restart_addr", mem_addr, 32'h0);
    chk("ar_restart_enable", 32'(mem_enable), 32'd1);
    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0);
    chk("ar_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
